// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
// Bus field widths live here so the request register can be a single packed struct.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  localparam int ARB_FIXED_D = 0;
  localparam int ARB_RR      = 1;

  // Instruction fetches are always 4-byte reads.
  localparam logic [2:0] I_FETCH_SIZE = 3'd2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [MEM_STRB_W-1:0] strobe;
    logic [MEM_DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic owner_e owner_of(input arb_state_e s);
    case (s)
      BUSY_I:  return OWN_I;
      BUSY_D:  return OWN_D;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker: a lone requester always wins; ties go to D,
// or in round-robin mode to whichever requester was not granted last.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_e last_grant,
  input  logic   mode,
  output logic   grant_i,
  output logic   grant_d
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (req_i && req_d) begin
      if (mode && (last_grant == OWN_D)) grant_i = 1'b1;
      else                               grant_d = 1'b1;
    end else begin
      grant_i = req_i;
      grant_d = req_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch (I) and memory (D) stages with a
// single outstanding transaction; the bus request is registered and held until m_data_ok.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int ADDR_W   = MEM_ADDR_W,
  parameter  int DATA_W   = MEM_DATA_W,
  parameter  int ARB_MODE = ARB_FIXED_D,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic [STRB_W-1:0] d_strobe,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [2:0]        m_size,
  output logic [STRB_W-1:0] m_strobe,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        owner
);

  arb_state_e state;
  owner_e     last_grant;
  logic       abandon;
  bus_req_t   m_req;
  bus_req_t   i_req;
  bus_req_t   d_req;
  logic       grant_i;
  logic       grant_d;
  logic       owner_valid;
  logic       deliver;

  always_comb begin
    i_req        = '0;
    i_req.addr   = MEM_ADDR_W'(i_addr);
    i_req.size   = I_FETCH_SIZE;
    d_req        = '0;
    d_req.addr   = MEM_ADDR_W'(d_addr);
    d_req.size   = d_size;
    d_req.strobe = MEM_STRB_W'(d_strobe);
    d_req.wdata  = MEM_DATA_W'(d_wdata);
  end

  arb_pick2 u_pick (
    .req_i      (i_valid),
    .req_d      (d_valid),
    .last_grant (last_grant),
    .mode       (ARB_MODE == ARB_RR),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      m_valid    <= 1'b0;
      m_req      <= '0;
      last_grant <= OWN_I;
      abandon    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          abandon <= 1'b0;
          if (grant_d) begin
            state      <= BUSY_D;
            m_valid    <= 1'b1;
            m_req      <= d_req;
            last_grant <= OWN_D;
          end else if (grant_i) begin
            state      <= BUSY_I;
            m_valid    <= 1'b1;
            m_req      <= i_req;
            last_grant <= OWN_I;
          end
        end
        BUSY_I, BUSY_D: begin
          // A bus request cannot be withdrawn, so an abandoned one still runs to completion.
          if (m_data_ok) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            abandon <= 1'b0;
          end else if (!owner_valid) begin
            abandon <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign owner_valid = (state == BUSY_I) ? i_valid : d_valid;
  assign deliver     = m_data_ok && !abandon && owner_valid;

  assign i_data_ok = deliver && (state == BUSY_I);
  assign d_data_ok = deliver && (state == BUSY_D);
  assign i_rdata   = (state == BUSY_I) ? m_rdata : '0;
  assign d_rdata   = (state == BUSY_D) ? m_rdata : '0;

  assign m_addr   = m_req.addr[ADDR_W-1:0];
  assign m_size   = m_req.size;
  assign m_strobe = m_req.strobe[STRB_W-1:0];
  assign m_wdata  = m_req.wdata[DATA_W-1:0];
  assign owner    = owner_of(state);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a fixed-D instance and a round-robin
// instance share stimulus; a scoreboard checks every grant and response of the fixed-D instance.
module tb_mem_bus_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid;
  logic [AW-1:0] i_addr;
  logic          d_valid;
  logic [AW-1:0] d_addr;
  logic [2:0]    d_size;
  logic [SW-1:0] d_strobe;
  logic [DW-1:0] d_wdata;
  logic          m_data_ok;
  logic [DW-1:0] m_rdata;

  logic          i_ok0, d_ok0, mv0, i_ok1, d_ok1, mv1;
  logic [DW-1:0] i_rd0, d_rd0, mw0, i_rd1, d_rd1, mw1;
  logic [AW-1:0] ma0, ma1;
  logic [2:0]    ms0, ms1;
  logic [SW-1:0] mst0, mst1;
  logic [1:0]    own0, own1;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_ok0), .i_rdata(i_rd0),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_data_ok(d_ok0), .d_rdata(d_rd0),
    .m_valid(mv0), .m_addr(ma0), .m_size(ms0), .m_strobe(mst0), .m_wdata(mw0),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata), .owner(own0)
  );

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_ok1), .i_rdata(i_rd1),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_data_ok(d_ok1), .d_rdata(d_rd1),
    .m_valid(mv1), .m_addr(ma1), .m_size(ms1), .m_strobe(mst1), .m_wdata(mw1),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata), .owner(own1)
  );

  typedef struct {
    logic [1:0]  owner;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
  } grant_t;

  typedef struct {
    logic [1:0]  owner;
    logic [63:0] rdata;
  } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];
  grant_t g;
  resp_t  r;
  int     vectors = 0;
  int     miscompares = 0;
  logic   prev_mv = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void exp_grant_i(input logic [63:0] a);
    grant_q.push_back('{2'd1, a, 3'd2, 8'h00, 64'h0});
  endfunction

  function automatic void exp_grant_d(input logic [63:0] a, input logic [2:0] s,
                                      input logic [7:0] st, input logic [63:0] w);
    grant_q.push_back('{2'd2, a, s, st, w});
  endfunction

  function automatic void exp_resp(input logic [1:0] o, input logic [63:0] d);
    resp_q.push_back('{o, d});
  endfunction

  // Scoreboard for the fixed-D instance: each new grant and each data_ok must be expected.
  always @(negedge clk) begin
    if (!reset) begin
      prev_mv = 1'b0;
    end else begin
      if (mv0 && !prev_mv) begin
        check("grant_expected", 64'(grant_q.size() != 0), 64'd1);
        if (grant_q.size() != 0) begin
          g = grant_q.pop_front();
          check("sb_owner", own0, g.owner);
          check("sb_m_addr", ma0, g.addr);
          check("sb_m_size", ms0, g.size);
          check("sb_m_strobe", mst0, g.strobe);
          check("sb_m_wdata", mw0, g.wdata);
        end
      end
      prev_mv = mv0;
      if (i_ok0 || d_ok0) begin
        check("resp_expected", 64'(resp_q.size() != 0), 64'd1);
        if (resp_q.size() != 0) begin
          r = resp_q.pop_front();
          check("sb_i_data_ok", i_ok0, r.owner == 2'd1);
          check("sb_d_data_ok", d_ok0, r.owner == 2'd2);
          check("sb_i_rdata", i_rd0, (r.owner == 2'd1) ? r.rdata : 64'h0);
          check("sb_d_rdata", d_rd0, (r.owner == 2'd2) ? r.rdata : 64'h0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_size = '0;
    d_strobe = '0; d_wdata = '0; m_data_ok = 0; m_rdata = '0;
    #1 reset = 1'b0;
    #1;
    check("rst_m_valid", mv0, 0);
    check("rst_owner", own0, 0);
    check("rst_m_addr", ma0, 0);
    check("rst_m_strobe", mst0, 0);
    check("rst_i_data_ok", i_ok0, 0);
    check("rst_d_data_ok", d_ok0, 0);
    cyc(2);
    reset = 1'b1;
    cyc(1);

    // Single fetch: one-cycle request latency, completion three cycles after the request.
    i_valid = 1; i_addr = 64'h8000_0000;
    exp_grant_i(64'h8000_0000); exp_resp(2'd1, 64'h13);
    @(negedge clk);
    check("t1_latency_m_valid", mv0, 0);
    cyc(1);
    @(negedge clk);
    check("t1_m_valid", mv0, 1);
    check("t1_owner", own0, 1);
    check("t1_m_addr", ma0, 64'h8000_0000);
    check("t1_m_strobe", mst0, 0);
    cyc(2);
    m_data_ok = 1; m_rdata = 64'h13;
    @(negedge clk);
    check("t1_i_data_ok", i_ok0, 1);
    check("t1_i_rdata", i_rd0, 64'h13);
    check("t1_d_data_ok", d_ok0, 0);
    cyc(1);
    m_data_ok = 0; m_rdata = '0; i_valid = 0;
    @(negedge clk);
    check("t1_idle_owner", own0, 0);
    cyc(1);

    // Simultaneous requests, fixed priority: D first, I one idle cycle after D completes.
    i_valid = 1; i_addr = 64'h2000;
    d_valid = 1; d_addr = 64'h100; d_size = 3'd3; d_strobe = 8'hFF; d_wdata = 64'hAB;
    exp_grant_d(64'h100, 3'd3, 8'hFF, 64'hAB); exp_grant_i(64'h2000);
    exp_resp(2'd2, 64'h55); exp_resp(2'd1, 64'h66);
    cyc(1);
    @(negedge clk);
    check("t2_owner_d", own0, 2);
    check("t2_m_wdata", mw0, 64'hAB);
    cyc(1);
    m_data_ok = 1; m_rdata = 64'h55;
    @(negedge clk);
    check("t2_d_data_ok", d_ok0, 1);
    check("t2_i_data_ok", i_ok0, 0);
    check("t2_i_rdata_zero", i_rd0, 0);
    cyc(1);
    m_data_ok = 0; d_valid = 0;
    @(negedge clk);
    check("t2_gap_m_valid", mv0, 0);
    check("t2_gap_owner", own0, 0);
    cyc(1);
    @(negedge clk);
    check("t2_owner_i", own0, 1);
    check("t2_i_size", ms0, 2);
    check("t2_i_wdata", mw0, 0);
    cyc(1);
    m_data_ok = 1; m_rdata = 64'h66;
    cyc(1);
    m_data_ok = 0; i_valid = 0;
    cyc(1);

    // Both held for four transactions: fixed mode always D, round-robin alternates from D.
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    i_valid = 1; i_addr = 64'h3000;
    d_valid = 1; d_addr = 64'h4000; d_size = 3'd3; d_strobe = 8'h0F; d_wdata = 64'hD0;
    for (int k = 0; k < 4; k++) begin
      exp_grant_d(64'h4000, 3'd3, 8'h0F, 64'hD0);
      exp_resp(2'd2, 64'h70 + 64'(k));
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      m_data_ok = 1; m_rdata = 64'h70 + 64'(k);
      @(negedge clk);
      if (k % 2 == 0) begin
        check("t3_rr_owner_d", own1, 2);
        check("t3_rr_m_addr_d", ma1, 64'h4000);
        check("t3_rr_m_size_d", ms1, 3);
        check("t3_rr_m_strobe_d", mst1, 8'h0F);
        check("t3_rr_m_wdata_d", mw1, 64'hD0);
        check("t3_rr_d_ok", d_ok1, 1);
        check("t3_rr_d_rdata", d_rd1, 64'h70 + 64'(k));
        check("t3_rr_i_ok_quiet", i_ok1, 0);
      end else begin
        check("t3_rr_owner_i", own1, 1);
        check("t3_rr_m_addr_i", ma1, 64'h3000);
        check("t3_rr_m_size_i", ms1, 2);
        check("t3_rr_m_strobe_i", mst1, 0);
        check("t3_rr_m_wdata_i", mw1, 0);
        check("t3_rr_i_ok", i_ok1, 1);
        check("t3_rr_i_rdata", i_rd1, 64'h70 + 64'(k));
        check("t3_rr_d_ok_quiet", d_ok1, 0);
      end
      check("t3_fixed_owner", own0, 2);
      cyc(1);
      m_data_ok = 0;
    end
    i_valid = 0; d_valid = 0;
    cyc(1);

    // Abandon: I drops valid at cycle 2, bus completes at cycle 4, no fetch response.
    i_valid = 1; i_addr = 64'h5000;
    exp_grant_i(64'h5000);
    cyc(1);
    @(negedge clk);
    check("t4_c1_m_valid", mv0, 1);
    cyc(1);
    i_valid = 0;
    @(negedge clk);
    check("t4_c2_m_valid", mv0, 1);
    check("t4_c2_owner", own0, 1);
    cyc(1);
    @(negedge clk);
    check("t4_c3_m_valid", mv0, 1);
    cyc(1);
    m_data_ok = 1; m_rdata = 64'h99;
    @(negedge clk);
    check("t4_c4_m_valid", mv0, 1);
    check("t4_c4_i_data_ok", i_ok0, 0);
    check("t4_c4_rr_i_data_ok", i_ok1, 0);
    cyc(1);
    m_data_ok = 0;
    @(negedge clk);
    check("t4_c5_owner", own0, 0);
    check("t4_c5_m_valid", mv0, 0);
    cyc(1);
    m_data_ok = 1; m_rdata = 64'hEE;
    @(negedge clk);
    check("t4_idle_i_data_ok", i_ok0, 0);
    check("t4_idle_d_data_ok", d_ok0, 0);
    check("t4_idle_owner", own0, 0);
    cyc(1);
    m_data_ok = 0;
    i_valid = 1; i_addr = 64'h5008;
    exp_grant_i(64'h5008); exp_resp(2'd1, 64'h77);
    cyc(1);
    m_data_ok = 1; m_rdata = 64'h77;
    @(negedge clk);
    check("t4_fresh_i_data_ok", i_ok0, 1);
    cyc(1);
    m_data_ok = 0; i_valid = 0;
    cyc(1);

    // Reset mid-transaction drops the bus request without a clock edge, then re-grants.
    d_valid = 1; d_addr = 64'h600; d_size = 3'd2; d_strobe = 8'h0F; d_wdata = 64'h1234;
    exp_grant_d(64'h600, 3'd2, 8'h0F, 64'h1234);
    cyc(1);
    @(negedge clk);
    check("t5_busy_owner", own0, 2);
    check("t5_busy_m_valid", mv0, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_async_m_valid", mv0, 0);
    check("t5_async_owner", own0, 0);
    check("t5_async_m_strobe", mst0, 0);
    check("t5_async_rr_m_valid", mv1, 0);
    cyc(1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_release_m_valid", mv0, 0);
    exp_grant_d(64'h600, 3'd2, 8'h0F, 64'h1234);
    exp_resp(2'd2, 64'hCAFE);
    cyc(1);
    @(negedge clk);
    check("t5_regrant_m_valid", mv0, 1);
    check("t5_regrant_owner", own0, 2);
    cyc(1);
    m_data_ok = 1; m_rdata = 64'hCAFE;
    cyc(1);
    m_data_ok = 0; d_valid = 0;
    cyc(2);

    check("end_grant_q_empty", 64'(grant_q.size()), 0);
    check("end_resp_q_empty", 64'(resp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
